perf_counter_bank: RTL
======================

Name: perf_counter_bank

Overview:
- Parametrised successor to the single-purpose stall/bubble counter in the pipeline datapath.
- Provides NUM_CH independent event counters with:
  - a global enable;
  - per-channel and global clear;
  - an atomic snapshot into shadow registers;
  - selectable saturate or wrap mode;
  - sticky overflow flags.
- Sits beside the pipeline and caches.
  - Event strobes come from hazard detection (pc_stall) and the L1I/L1D/L2 miss pulses.
  - The execute stage reads counters through a registered select/read port.

Parameters:
- NUM_CH, 8, number of counter channels (1..32).
- CNT_W, 16, counter width in bits (lc3b_word width by default; 2..32).
- SATURATE, 0, 1 = counters stick at all-ones on overflow; 0 = counters wrap to zero.
- SEL_W, $clog2(NUM_CH) (minimum 1), width of the channel select fields.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- event_in  in  NUM_CH  per-channel event strobe; counts +1 per cycle while high.
- enable  in  1  global count enable; events are ignored when low.
- clr  in  1  clear the channel addressed by clr_sel.
- clr_sel  in  SEL_W  channel index for clr.
- clr_all  in  1  clear all channels.
- snap  in  1  copy all live counts into the shadow registers.
- rd_req  in  1  read request.
- rd_sel  in  SEL_W  channel index to read.
- rd_shadow  in  1  1 = read the shadow copy; 0 = read the live count.
- rd_data  out  CNT_W  read data, registered.
- rd_valid  out  1  high for one cycle, the cycle after rd_req.
- ovf  out  NUM_CH  sticky per-channel overflow flags.

Behaviour:
- Reset (synchronous, active-high):
  - All live counts, shadow counts, ovf, rd_data and rd_valid are 0.
  - Reset asserted mid-operation overrides every other input that cycle.
- Counting:
  - Each cycle, if enable and event_in[i] are both high, count[i] increments by 1.
  - Arithmetic is unsigned, CNT_W bits.
- Overflow, on an increment when count[i] is all-ones:
  - SATURATE=1: count holds at all-ones and ovf[i] sets.
  - SATURATE=0: count becomes 0 and ovf[i] sets.
  - ovf[i] stays set until channel i is cleared or reset.
- Clear:
  - clr clears count[i] and ovf[i] for i == clr_sel.
  - clr_all clears every channel; shadow registers are untouched.
  - Clear takes priority over an increment in the same cycle: result is 0, the event is dropped, ovf is 0.
  - clr_sel >= NUM_CH has no effect.
- Snapshot:
  - snap loads shadow[i] with the pre-update count[i] for all i, in one cycle.
  - Events arriving in the same cycle land in the live counts only.
  - snap together with clr/clr_all: the shadow gets the pre-clear values.
- Read:
  - Latency is 1 cycle. rd_data and rd_valid update on the edge after rd_req is sampled high.
  - Data returned is the pre-update value: live count or shadow, chosen by rd_shadow.
  - A read in the same cycle as a clear or increment of that channel returns the old value.
  - rd_sel >= NUM_CH returns 0, with rd_valid still asserted.
  - When rd_req is low, rd_valid is 0 and rd_data holds its last value.
  - Back-to-back reads are supported, one per cycle.
- enable low: counts freeze. Clear, snapshot and read still operate.
- There is no FSM beyond the per-channel state. All control signals are sampled every cycle with no handshake stall.

Decomposition:
- Shared package lc3b_perf_types holds the channel index constants:
  - PERF_BUBBLE=0, PERF_L1I_RMISS=1, PERF_L1I_WMISS=2, PERF_L1D_RMISS=3;
  - PERF_L1D_WMISS=4, PERF_L2_RMISS=5, PERF_L2_WMISS=6, PERF_RSVD=7;
  - PERF_NUM_CH=8.
- Sub-module perf_counter_channel, parametrised by CNT_W and SATURATE:
  - contains one live counter, its shadow and its ovf bit;
  - inputs: inc, clr, snap.
- Top level generates NUM_CH channels, decodes clr_sel, and holds the registered read mux.

Test Plan:
1. Reset, then enable=1 with event_in[3] held high for 10 cycles, then rd_req, rd_sel=3 → next cycle rd_valid=1, rd_data=10; other channels read 0.
2. CNT_W=4, SATURATE=0: 17 events on ch0 → count=1, ovf[0]=1. Then clr with clr_sel=0 → count=0, ovf[0]=0. Repeat with SATURATE=1 → count=15, ovf[0]=1.
3. ch2 at count 5: assert clr (clr_sel=2), event_in[2] and rd_req (rd_sel=2) in the same cycle → rd_data=5, count afterwards=0.
4. ch1 at count 7: snap together with an event on ch1 → shadow=7, live=8. Then rd_shadow=1 reads 7 and rd_shadow=0 reads 8.
5. enable=0 with all events high for 20 cycles → all counts unchanged. rd_sel=NUM_CH (with NUM_CH=6) → rd_data=0, rd_valid=1.
6. Counts nonzero: reset asserted for one cycle alongside clr_all and snap → every count, shadow, ovf, rd_data and rd_valid is 0 on the next cycle.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_perf_types
//
// Shared definitions for the performance counter bank.
//
// Channel indices
//   Each index names the event strobe wired into that channel:
//   - PERF_BUBBLE     : pc_stall from hazard detection.
//   - PERF_L1I_*      : L1I read and write miss pulses.
//   - PERF_L1D_*      : L1D read and write miss pulses.
//   - PERF_L2_*       : L2 read and write miss pulses.
//   - PERF_RSVD       : spare channel.
//
// Helper
//   sel_width() gives the width of a channel select field. It never returns
//   less than 1, so a single-channel bank still has a legal select port.
// -----------------------------------------------------------------------------
package lc3b_perf_types;

   localparam int PERF_BUBBLE    = 0;
   localparam int PERF_L1I_RMISS = 1;
   localparam int PERF_L1I_WMISS = 2;
   localparam int PERF_L1D_RMISS = 3;
   localparam int PERF_L1D_WMISS = 4;
   localparam int PERF_L2_RMISS  = 5;
   localparam int PERF_L2_WMISS  = 6;
   localparam int PERF_RSVD      = 7;
   localparam int PERF_NUM_CH    = 8;

   // Width of a channel select field for a bank of n channels (minimum 1).
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/perf_counter_bank_channel.sv
// -----------------------------------------------------------------------------
// perf_counter_channel
//
// One counter channel. It holds a live event count, a shadow copy of that
// count, and a sticky overflow flag.
//
// Ports
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   inc     in   add one to the live count this cycle (already gated by enable)
//   clr     in   zero the live count and the overflow flag; wins over inc
//   snap    in   copy the pre-update live count into the shadow
//   count   out  live count
//   shadow  out  shadow copy of the count
//   ovf     out  sticky overflow flag
//
// Parameters
//   CNT_W     counter width in bits
//   SATURATE  1 = the count sticks at all-ones on overflow; 0 = it wraps to zero
// -----------------------------------------------------------------------------
module perf_counter_channel #(
   parameter int CNT_W    = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   input  logic             snap,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] shadow,
   output logic             ovf
);

   logic [CNT_W-1:0] count_q,  count_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             ovf_q,    ovf_d;

   always_comb begin
      // NOTE: every next-state value takes a default first, so a path that
      // assigns nothing holds the register instead of inferring a latch.
      count_d  = count_q;
      ovf_d    = ovf_q;
      // The shadow takes the value from before this cycle's clear or increment.
      shadow_d = snap ? count_q : shadow_q;

      if (clr) begin
         // A clear drops any event that arrives in the same cycle.
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (inc) begin
         if (&count_q) begin
            ovf_d   = 1'b1;
            count_d = SATURATE ? count_q : '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. All registers
   // then update together on the edge, whatever order the statements are in.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         // NOTE: the shadow copy also gets a reset. It is a plain register,
         // not a RAM, and software expects to read 0 from it after reset.
         shadow_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         shadow_q <= shadow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign count  = count_q;
   assign shadow = shadow_q;
   assign ovf    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//
// A bank of NUM_CH independent event counters. The bank sits beside the
// pipeline and the caches. Each channel counts +1 per cycle while its event
// strobe and the global enable are both high. A registered read port returns
// either the live count or its shadow copy.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   event_in   in   per-channel event strobes
//   enable     in   global count enable
//   clr        in   clear the channel addressed by clr_sel
//   clr_sel    in   channel index for clr; out-of-range values are ignored
//   clr_all    in   clear every channel (shadows are kept)
//   snap       in   copy every live count into its shadow
//   rd_req     in   read request
//   rd_sel     in   channel index to read; out-of-range values return 0
//   rd_shadow  in   1 = read the shadow copy, 0 = read the live count
//   rd_data    out  registered read data, held while no read is requested
//   rd_valid   out  high for one cycle, the cycle after rd_req
//   ovf        out  sticky per-channel overflow flags
// -----------------------------------------------------------------------------
module perf_counter_bank
   import lc3b_perf_types::*;
#(
   parameter int NUM_CH   = PERF_NUM_CH,
   parameter int CNT_W    = 16,
   parameter bit SATURATE = 1'b0,
   parameter int SEL_W    = sel_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] event_in,
   input  logic              enable,
   input  logic              clr,
   input  logic [SEL_W-1:0]  clr_sel,
   input  logic              clr_all,
   input  logic              snap,
   input  logic              rd_req,
   input  logic [SEL_W-1:0]  rd_sel,
   input  logic              rd_shadow,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic [NUM_CH-1:0] ovf
);

   logic [NUM_CH-1:0][CNT_W-1:0] live_cnt;
   logic [NUM_CH-1:0][CNT_W-1:0] shadow_cnt;
   logic [NUM_CH-1:0]            ch_inc;
   logic [NUM_CH-1:0]            ch_clr;

   // ---------------------------------------------------------------------------
   // Channels
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_inc[i] = enable & event_in[i];
      // clr_sel values at or above NUM_CH match no channel, so they do nothing.
      assign ch_clr[i] = clr_all | (clr & (clr_sel == SEL_W'(i)));

      perf_counter_channel #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk    (clk),
         .reset  (reset),
         .inc    (ch_inc[i]),
         .clr    (ch_clr[i]),
         .snap   (snap),
         .count  (live_cnt[i]),
         .shadow (shadow_cnt[i]),
         .ovf    (ovf[i])
      );
   end

   // ---------------------------------------------------------------------------
   // Registered read port
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] rd_word;
   logic [CNT_W-1:0] rd_data_q,  rd_data_d;
   logic             rd_valid_q, rd_valid_d;

   // The mux reads register outputs, so a read always returns the value from
   // before any clear or increment in the same cycle. The mux compares rd_sel
   // with each channel index, so an rd_sel that matches no channel gives 0.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            rd_word = rd_shadow ? shadow_cnt[i] : live_cnt[i];
         end
      end
   end

   always_comb begin
      rd_valid_d = rd_req;
      rd_data_d  = rd_req ? rd_word : rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule
